// File: rtl/vending_credit_ctrl_pkg.sv
// Constants shared by the vending blocks: coin values, FSM state encoding
// and the legal-coin check.
package vend_pkg;

    localparam logic [3:0] COIN_1  = 4'd1;
    localparam logic [3:0] COIN_5  = 4'd5;
    localparam logic [3:0] COIN_10 = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_COLLECT  = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } vend_state_t;

    function automatic logic is_legal_coin(input logic [3:0] value);
        return (value == COIN_1) || (value == COIN_5) || (value == COIN_10);
    endfunction

endpackage

// File: rtl/vending_credit_ctrl_if.sv
// Coin/keypad front-end signals and dispenser/hopper responses of the
// credit controller, bundled for connection between front end and controller.
interface vending_credit_ctrl_if #(
    parameter int CREDIT_W = 6
) ();
    logic                coin_strobe;
    logic [3:0]          coin_input;
    logic                buy;
    logic                cancel;
    logic                coin_accept;
    logic                coin_reject;
    logic                buy_denied;
    logic                dispense;
    logic                change_valid;
    logic [3:0]          change_coin;
    logic [CREDIT_W-1:0] credit;
    logic                busy;

    modport master (
        output coin_strobe, coin_input, buy, cancel,
        input  coin_accept, coin_reject, buy_denied, dispense,
               change_valid, change_coin, credit, busy
    );

    modport slave (
        input  coin_strobe, coin_input, buy, cancel,
        output coin_accept, coin_reject, buy_denied, dispense,
               change_valid, change_coin, credit, busy
    );
endinterface

// File: rtl/vending_credit_ctrl_change_coin_picker.sv
// Greedy change selection: largest of 10/5/1 not exceeding the credit,
// or 0 when there is no credit left.
module change_coin_picker
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 6
) (
    input  logic [CREDIT_W-1:0] credit,
    output logic [3:0]          coin
);
    always_comb begin
        coin = 4'd0;
        if (credit >= CREDIT_W'(COIN_10)) begin
            coin = COIN_10;
        end else if (credit >= CREDIT_W'(COIN_5)) begin
            coin = COIN_5;
        end else if (credit >= CREDIT_W'(COIN_1)) begin
            coin = COIN_1;
        end
    end
endmodule

// File: rtl/vending_credit_ctrl.sv
// Coin-path sequencing controller: coin classification, credit accumulation,
// buy/cancel arbitration and one-coin-per-cycle greedy change return.
module vending_credit_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE      = 15,
    parameter int MAX_CREDIT = 30,
    parameter int CREDIT_W   = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vending_credit_ctrl_if.slave  bus
);
    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W:0]   MAX_C   = (CREDIT_W + 1)'(MAX_CREDIT);

    vend_state_t         state_reg, state_next;
    logic [CREDIT_W-1:0] credit_reg, credit_next;
    logic                coin_accept_reg, coin_accept_next;
    logic                coin_reject_reg, coin_reject_next;
    logic                buy_denied_reg, buy_denied_next;
    logic                dispense_reg, dispense_next;
    logic                change_valid_reg, change_valid_next;
    logic [3:0]          change_coin_reg, change_coin_next;

    logic [3:0]          pick_coin;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_ok;
    logic                can_buy;
    logic [CREDIT_W-1:0] after_price;
    logic [CREDIT_W-1:0] after_change;

    change_coin_picker #(.CREDIT_W(CREDIT_W)) u_picker (
        .credit (credit_reg),
        .coin   (pick_coin)
    );

    // A coin is only taken when neither buy nor cancel claims the cycle.
    assign coin_sum     = {1'b0, credit_reg} + (CREDIT_W + 1)'(bus.coin_input);
    assign coin_ok      = bus.coin_strobe && !bus.buy && !bus.cancel &&
                          is_legal_coin(bus.coin_input) && (coin_sum <= MAX_C);
    assign can_buy      = credit_reg >= PRICE_C;
    assign after_price  = credit_reg - PRICE_C;
    assign after_change = credit_reg - CREDIT_W'(pick_coin);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg        <= S_IDLE;
            credit_reg       <= '0;
            coin_accept_reg  <= 1'b0;
            coin_reject_reg  <= 1'b0;
            buy_denied_reg   <= 1'b0;
            dispense_reg     <= 1'b0;
            change_valid_reg <= 1'b0;
            change_coin_reg  <= 4'd0;
        end else begin
            state_reg        <= state_next;
            credit_reg       <= credit_next;
            coin_accept_reg  <= coin_accept_next;
            coin_reject_reg  <= coin_reject_next;
            buy_denied_reg   <= buy_denied_next;
            dispense_reg     <= dispense_next;
            change_valid_reg <= change_valid_next;
            change_coin_reg  <= change_coin_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE, S_COLLECT: begin
                if (bus.buy) begin
                    if (can_buy) state_next = S_DISPENSE;
                end else if (bus.cancel) begin
                    if (state_reg == S_COLLECT) state_next = S_CHANGE;
                end else if (coin_ok) begin
                    state_next = S_COLLECT;
                end
            end
            S_DISPENSE: state_next = (after_price != '0) ? S_CHANGE : S_IDLE;
            S_CHANGE:   state_next = (after_change != '0) ? S_CHANGE : S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    always_comb begin
        credit_next       = credit_reg;
        coin_accept_next  = 1'b0;
        coin_reject_next  = 1'b0;
        buy_denied_next   = 1'b0;
        dispense_next     = 1'b0;
        change_valid_next = 1'b0;
        change_coin_next  = 4'd0;
        case (state_reg)
            S_IDLE, S_COLLECT: begin
                if (bus.buy && !can_buy) buy_denied_next = 1'b1;
                if (coin_ok) begin
                    credit_next      = coin_sum[CREDIT_W-1:0];
                    coin_accept_next = 1'b1;
                end else if (bus.coin_strobe) begin
                    coin_reject_next = 1'b1;
                end
            end
            S_DISPENSE: begin
                dispense_next    = 1'b1;
                credit_next      = after_price;
                coin_reject_next = bus.coin_strobe;
            end
            S_CHANGE: begin
                change_valid_next = 1'b1;
                change_coin_next  = pick_coin;
                credit_next       = after_change;
                coin_reject_next  = bus.coin_strobe;
            end
            default: credit_next = '0;
        endcase
    end

    assign bus.coin_accept  = coin_accept_reg;
    assign bus.coin_reject  = coin_reject_reg;
    assign bus.buy_denied   = buy_denied_reg;
    assign bus.dispense     = dispense_reg;
    assign bus.change_valid = change_valid_reg;
    assign bus.change_coin  = change_coin_reg;
    assign bus.credit       = credit_reg;
    assign bus.busy         = (state_reg == S_DISPENSE) || (state_reg == S_CHANGE);
endmodule
